// File: rtl/ann_pkg.sv
// ann_pkg: data width, signed data type and streamer state encoding shared with the layer datapath
package ann_pkg;
  localparam int DATA_W = 16;
  typedef logic signed [DATA_W-1:0] data_t;
  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/ann_out_buf.sv
// ann_out_buf: N_OUT x DATA_W neuron-output register file, sync write/clear, comb read
//   clk, rst       clock, sync active-high reset (clears all entries)
//   we_i, waddr_i, wdata_i  single-word write
//   clr_i          clear every entry (wins over we_i)
//   ridx_i, rdata_o         combinational read port
module ann_out_buf
  import ann_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = ann_pkg::DATA_W,
  parameter int IDX_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [N_OUT];
  always_ff @(posedge clk)
    for (int i = 0; i < N_OUT; i++)
      if (rst || clr_i) mem_q[i] <= '0;
      else if (we_i && waddr_i == IDX_W'(i)) mem_q[i] <= wdata_i;
  assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/ann_output_streamer.sv
// ann_output_streamer: buffers N_OUT neuron results and streams them in index order over AXI4-Stream
//   clk, rst                     clock, sync active-high reset (aborts any stream, no done)
//   wr_en, wr_addr, wr_data      buffer write, honoured in IDLE only
//   buf_clr                      clear whole buffer, IDLE only, beats wr_en
//   start                        begin streaming, sampled in IDLE only
//   busy, done                   streaming flag; one-cycle pulse after the final word
//   m_axis_tdata/tvalid/tready/tlast  AXI4-Stream master
module ann_output_streamer
  import ann_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = ann_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(N_OUT)-1:0] wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     buf_clr,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);
  localparam int IDX_W = $clog2(N_OUT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic done_q, done_d;
  logic idle, hs, last, we;
  logic [DATA_W-1:0] rdata;
  assign idle = state_q == IDLE;
  assign hs   = m_axis_tvalid && m_axis_tready;
  assign last = idx_q == LAST;
  // out-of-range addresses are dropped rather than aliased onto a real entry
  assign we   = idle && wr_en && (32'(wr_addr) < N_OUT);
  ann_out_buf #(.N_OUT(N_OUT), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .clr_i   (idle && buf_clr),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .ridx_i  (idx_q),
    .rdata_o (rdata)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (idle && start) begin
      state_d = STREAM;
      idx_d   = '0;
    end else if (!idle && hs) begin
      state_d = last ? IDLE : STREAM;
      idx_d   = last ? '0 : idx_q + 1'b1;
      done_d  = last;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  assign busy          = !idle;
  assign done          = done_q;
  assign m_axis_tvalid = !idle;
  assign m_axis_tlast  = !idle && last;
  assign m_axis_tdata  = $signed(rdata);
endmodule

// File: tb/tb_ann_output_streamer.sv
// tb_ann_output_streamer: directed self-checking bench for ann_output_streamer
module tb_ann_output_streamer;
  logic clk = 0, rst = 1, wr_en = 0, buf_clr = 0, start = 0, m_axis_tready = 0;
  logic [1:0] wr_addr = 0;
  logic signed [15:0] wr_data = 0;
  logic busy, done, m_axis_tvalid, m_axis_tlast;
  logic signed [15:0] m_axis_tdata;
  int vecs = 0, errs = 0;
  localparam logic [63:0] D_ZERO = 64'h0;
  localparam logic [63:0] D_MAIN = 64'h8000_012C_FF38_0064;
  localparam logic [63:0] D_55   = 64'h8000_012C_FF38_0037;
  localparam logic [63:0] D_1234 = 64'h0004_0003_0002_0001;
  always #5 clk = ~clk;
  ann_output_streamer #(.N_OUT(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .buf_clr(buf_clr), .start(start), .busy(busy), .done(done),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic run_stream(input string tag, input logic [63:0] e, input logic [6:0] pat, input int poke);
    int n = 0;
    int c = 0;
    logic stall = 0;
    logic signed [31:0] held = 0;
    while (n < 4 && c < 40) begin
      @(negedge clk);
      start = 0; wr_en = 0; buf_clr = 0;
      chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 1);
      if (stall) chk({tag, "_hold"}, 32'({m_axis_tlast, m_axis_tdata}), held);
      if (c == poke) begin
        wr_en = 1; wr_addr = 1; wr_data = 7; buf_clr = 1; start = 1;
      end
      m_axis_tready = pat[c % 7];
      stall = !m_axis_tready;
      held = 32'({m_axis_tlast, m_axis_tdata});
      if (m_axis_tready) begin
        chk($sformatf("%s_w%0d", tag, n), 32'(m_axis_tdata), 32'($signed(e[16*n +: 16])));
        chk($sformatf("%s_last%0d", tag, n), 32'(m_axis_tlast), 32'(n == 3));
        n++;
      end
      c++;
    end
    if (n < 4) chk({tag, "_timeout"}, n, 4);
  endtask
  task automatic finish_chk(input string tag, input logic b2b);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_tvalid_end"}, 32'(m_axis_tvalid), 0);
    start = b2b;
    if (!b2b) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 0;
    start = 1;
    run_stream("t1", D_ZERO, 7'h7F, -1);
    finish_chk("t1", 0);
    wr(0, 16'h0064); wr(1, 16'hFF38); wr(2, 16'h012C); wr(3, 16'h8000);
    start = 1;
    run_stream("t2", D_MAIN, 7'h7F, -1);
    finish_chk("t2", 0);
    start = 1;
    run_stream("t3", D_MAIN, 7'b1101001, -1);
    finish_chk("t3", 0);
    start = 1;
    run_stream("t4a", D_MAIN, 7'h7F, 1);
    finish_chk("t4a", 0);
    start = 1;
    run_stream("t4b", D_MAIN, 7'h7F, -1);
    finish_chk("t4b", 0);
    wr_en = 1; wr_addr = 0; wr_data = 55; start = 1;
    run_stream("t4c", D_55, 7'h7F, -1);
    finish_chk("t4c", 0);
    start = 1; m_axis_tready = 1;
    @(negedge clk); start = 0;
    chk("t5_w0", 32'(m_axis_tdata), 55);
    @(negedge clk);
    chk("t5_w1", 32'(m_axis_tdata), -200);
    @(negedge clk);
    chk("t5_w2", 32'(m_axis_tdata), 300);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("t5_tvalid", 32'(m_axis_tvalid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    @(negedge clk);
    chk("t5_no_done", 32'(done), 0);
    start = 1;
    run_stream("t5z", D_ZERO, 7'h7F, -1);
    finish_chk("t5z", 0);
    wr(0, 16'd1); wr(1, 16'd2); wr(2, 16'd3); wr(3, 16'd4);
    start = 1;
    run_stream("t6a", D_1234, 7'h7F, -1);
    finish_chk("t6a", 1);
    run_stream("t6b", D_1234, 7'h7F, -1);
    finish_chk("t6b", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
